// File: rtl/qix_sound_cmd_tx.sv
// Data-CPU side of the sound command link: command/strobe/acknowledge handshake,
// reply latch with IRQ, and the stereo volume register. Optional QIX_SND_CMD_FIFO_EN adds a 4-deep command queue.
module qix_sound_cmd_tx #(
    parameter int unsigned STROBE_CYCLES  = 22,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic       clk_20m,
    input  logic       reset_n,
    input  logic       cs,
    input  logic       rw,
    input  logic [1:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       irq,
    output logic [7:0] snd_cmd,
    output logic       snd_strobe,
    input  logic [7:0] snd_reply,
    input  logic       snd_ack,
    output logic [7:0] vol_data
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STROBE   = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_t;

    localparam logic [15:0] STROBE_LAST  = 16'(STROBE_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_reg;
    logic [15:0] cnt_reg;
    logic        ack_prev_reg;
    logic        ack_flag_reg;
    logic        timeout_flag_reg;
    logic        overrun_flag_reg;
    logic        irq_en_reg;
    logic [7:0]  reply_reg;

    logic        wr_cmd;
    logic        wr_ctrl;
    logic        wr_vol;
    logic        ack_fall;
    logic        busy;
    logic        start_cmd;
    logic [7:0]  start_data;
    logic        overrun_set;
    logic        timeout_hit;

    assign wr_cmd   = cs & ~rw & (addr == 2'd0);
    assign wr_ctrl  = cs & ~rw & (addr == 2'd1);
    assign wr_vol   = cs & ~rw & (addr == 2'd2);
    assign ack_fall = ack_prev_reg & ~snd_ack;

`ifdef QIX_SND_CMD_FIFO_EN
    logic [7:0] fifo_mem [4];
    logic [1:0] fifo_wr_ptr_reg;
    logic [1:0] fifo_rd_ptr_reg;
    logic [2:0] fifo_count_reg;
    logic       fifo_empty;
    logic       fifo_full;
    logic       fifo_push;
    logic       fifo_pop;

    assign fifo_empty = (fifo_count_reg == 3'd0);
    assign fifo_full  = (fifo_count_reg == 3'd4);
    assign fifo_push  = wr_cmd & ~fifo_full;
    assign fifo_pop   = (state_reg == ST_IDLE) & ~fifo_empty;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_fifo_entry
            always_ff @(posedge clk_20m) begin
                if (fifo_push && (fifo_wr_ptr_reg == 2'(gi))) begin
                    fifo_mem[gi] <= data_in;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_20m or negedge reset_n) begin
        if (!reset_n) begin
            fifo_wr_ptr_reg <= 2'd0;
            fifo_rd_ptr_reg <= 2'd0;
            fifo_count_reg  <= 3'd0;
        end else begin
            if (fifo_push) begin
                fifo_wr_ptr_reg <= fifo_wr_ptr_reg + 2'd1;
            end
            if (fifo_pop) begin
                fifo_rd_ptr_reg <= fifo_rd_ptr_reg + 2'd1;
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count_reg <= fifo_count_reg + 3'd1;
                2'b01:   fifo_count_reg <= fifo_count_reg - 3'd1;
                default: fifo_count_reg <= fifo_count_reg;
            endcase
        end
    end

    assign busy        = (state_reg != ST_IDLE) | ~fifo_empty;
    assign start_cmd   = fifo_pop;
    assign start_data  = fifo_mem[fifo_rd_ptr_reg];
    assign overrun_set = wr_cmd & fifo_full;
`else
    assign busy        = (state_reg != ST_IDLE);
    assign start_cmd   = wr_cmd;
    assign start_data  = data_in;
    assign overrun_set = wr_cmd & (state_reg != ST_IDLE);
`endif

    // A restarting write abandons the in-flight command, so it does not also count as a timeout.
    assign timeout_hit = (state_reg == ST_WAIT_ACK) & ~ack_fall & ~start_cmd
                       & (cnt_reg == TIMEOUT_LAST);

    always_ff @(posedge clk_20m or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= 16'd0;
            snd_cmd    <= 8'd0;
            snd_strobe <= 1'b1;
        end else if (start_cmd) begin
            snd_cmd    <= start_data;
            snd_strobe <= 1'b0;
            cnt_reg    <= 16'd0;
            state_reg  <= ST_STROBE;
        end else begin
            case (state_reg)
                ST_STROBE: begin
                    if (cnt_reg == STROBE_LAST) begin
                        snd_strobe <= 1'b1;
                        cnt_reg    <= 16'd0;
                        state_reg  <= ST_WAIT_ACK;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                ST_WAIT_ACK: begin
                    if (ack_fall || cnt_reg == TIMEOUT_LAST) begin
                        cnt_reg   <= 16'd0;
                        state_reg <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                default: begin
                    cnt_reg   <= 16'd0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Flag set conditions take priority over same-cycle write-1-to-clear.
    always_ff @(posedge clk_20m or negedge reset_n) begin
        if (!reset_n) begin
            ack_prev_reg     <= 1'b0;
            ack_flag_reg     <= 1'b0;
            timeout_flag_reg <= 1'b0;
            overrun_flag_reg <= 1'b0;
            irq_en_reg       <= 1'b0;
            reply_reg        <= 8'd0;
            vol_data         <= 8'd0;
            irq              <= 1'b0;
        end else begin
            ack_prev_reg <= snd_ack;
            irq          <= irq_en_reg & ack_flag_reg;

            if (ack_fall) begin
                reply_reg <= snd_reply;
            end

            if (ack_fall) begin
                ack_flag_reg <= 1'b1;
            end else if (wr_ctrl && data_in[1]) begin
                ack_flag_reg <= 1'b0;
            end

            if (timeout_hit) begin
                timeout_flag_reg <= 1'b1;
            end else if (wr_ctrl && data_in[2]) begin
                timeout_flag_reg <= 1'b0;
            end

            if (overrun_set) begin
                overrun_flag_reg <= 1'b1;
            end else if (wr_ctrl && data_in[3]) begin
                overrun_flag_reg <= 1'b0;
            end

            if (wr_ctrl) begin
                irq_en_reg <= data_in[0];
            end

            if (wr_vol) begin
                vol_data <= data_in;
            end
        end
    end

    always_comb begin
        data_out = 8'hFF;
        case (addr)
            2'd0: data_out = reply_reg;
            2'd1: data_out = {ack_flag_reg, busy, timeout_flag_reg, overrun_flag_reg,
                              3'b000, irq_en_reg};
            2'd2: data_out = vol_data;
            default: begin
`ifdef QIX_SND_CMD_FIFO_EN
                data_out = {5'b00000, fifo_count_reg};
`else
                data_out = 8'hFF;
`endif
            end
        endcase
    end

endmodule
